// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, FSM state type and datapath width for the ALU arbiter.
package alu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SRA = 3'b100,
    OP_SLT = 3'b101,
    OP_XOR = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; shifts use the low 5 bits of b, SLT is an unsigned compare.
module alu
  import alu_pkg::*;
(
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);
  always_comb begin
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SRA:  y = $signed(a) >>> b[4:0];
      OP_SLT:  y = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  y = a ^ b;
      default: y = a << b[4:0];
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two request ports share one ALU; one operation in flight, round-robin or fixed-priority grant.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_src_a0,
  input  logic [31:0] req_src_b0,
  input  logic [31:0] req_src_a1,
  input  logic [31:0] req_src_b1,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        busy
);
  state_e            state_q, state_d;
  logic              owner_q, last_grant_q, grant, take;
  logic [XLEN-1:0]   a_q, b_q, alu_y;
  alu_op_e           op_q;
  alu u_alu (.op(op_q), .a(a_q), .b(b_q), .y(alu_y));
  // With both requesting, round-robin hands the slot to the port that did not win last time.
  assign grant = (RR_EN != 0 && (&req_valid)) ? ~last_grant_q : ~req_valid[0];
  assign take  = (state_q == S_IDLE) && (|req_valid) && rst_n;
  assign busy  = state_q != S_IDLE;
  always_comb begin
    state_d   = state_q;
    req_ready = take ? (grant ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      S_IDLE: state_d = take ? S_EXEC : S_IDLE;
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        state_d   = rsp_ready[owner_q] ? S_IDLE : S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        a_q          <= grant ? req_src_a1 : req_src_a0;
        b_q          <= grant ? req_src_b1 : req_src_b0;
        op_q         <= alu_op_e'(grant ? req_op1 : req_op0);
      end
      if (state_q == S_EXEC) begin
        rsp_result <= alu_y;
        rsp_zero   <= alu_y == '0;
      end
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 wins).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-port request valid (bit i = port i).
REQ-005 req_ready  output  2  per-port request accepted this cycle (one-hot or zero).
REQ-006 req_src_a0, req_src_b0, req_src_a1, req_src_b1  input  32 each  operands per port.
REQ-007 req_op0, req_op1  input  3 each  ALU operation code per port (package encoding).
REQ-008 rsp_valid  output  2  per-port response valid; at most one bit set.
REQ-009 rsp_ready  input  2  per-port response consumed.
REQ-010 rsp_result  output  32  result of the in-flight operation, shared by both ports.
REQ-011 rsp_zero  output  1  result equals zero.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one operation in flight.
REQ-014 IDLE: if any req_valid bit set, grant one port, assert its req_ready combinationally, latch its operands, opcode and owner ID, go to EXEC.
REQ-015 req_ready is zero in EXEC and RESP, and zero in IDLE when req_valid == 0.
REQ-016 RR_EN=1: both requesting -> grant port other than last_grant; one requesting -> grant it; last_grant updates on every grant.
REQ-017 RR_EN=0: port 0 wins on simultaneous requests; last_grant unused.
REQ-018 EXEC: ALU evaluates latched operands; result and zero flag registered; go to RESP.
REQ-019 RESP: rsp_valid[owner] high, rsp_result/rsp_zero stable until rsp_ready[owner] sampled high; then go to IDLE.
REQ-020 rsp_ready of the non-owner port is ignored.
REQ-021 Latency: accept at edge N -> rsp_valid high from edge N+2; min. issue interval 3 cycles per operation.
REQ-022 Operand handshake: a request is consumed only on cycle where req_valid[i] & req_ready[i]; requester holds operands until then.
REQ-023 Arithmetic: 32-bit, wraps modulo 2^32; shift amounts per ALU definition; SLT unsigned compare.
REQ-024 Requests arriving during EXEC/RESP wait; no queuing beyond the single in-flight slot.
REQ-025 rsp_result and rsp_zero hold last value when rsp_valid == 0 (not required to be zero).

Reset
REQ-026 rst_n low: state = IDLE, rsp_valid = 0, req_ready = 0, rsp_result = 0, rsp_zero = 0, last_grant = 1 (port 0 wins first), busy = 0.
REQ-027 Reset asserted mid-operation discards the in-flight operation; no response issued after release.
REQ-028 First grant possible in the first cycle after rst_n deasserts.

Structure
REQ-029 Shared package alu_pkg holds ALU opcode enum (ADD=000, SUB=001, AND=010, OR=011, SRA=100, SLT=101, XOR=110, SLL=111), FSM state typedef, and constant XLEN=32.
REQ-030 Sub-module: instantiate existing combinational alu exactly once, driven from latched operand registers.
REQ-031 Arbitration logic lives inline; no separate arbiter module.

Verification
REQ-032 Port 0 only: A=5, B=3, ADD -> req_ready[0] same cycle, rsp_valid[0] two cycles later, result 8, zero 0.
REQ-033 Both ports same cycle after reset, RR_EN=1: port0 SUB 7-7, port1 OR 0xF0|0x0F -> port 0 first (result 0, zero 1), then port 1 (result 0xFF).
REQ-034 Both held continuously, RR_EN=1, 4 operations -> grants alternate 0,1,0,1; RR_EN=0 -> all grants port 0.
REQ-035 Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid[0], result stable, req_ready=0, busy=1 throughout; release -> IDLE next cycle.
REQ-036 Wrap: ADD 0xFFFFFFFF+1 -> result 0, zero 1; SLL 1<<31 -> 0x80000000.
REQ-037 Reset during EXEC -> rsp_valid stays 0 after release, state IDLE, next request served normally.
